// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit_pkg
// Brief    : Shared encodings and types for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

    localparam logic [1:0]  PC_SEQ           = 2'b00;
    localparam logic [1:0]  PC_JUMP          = 2'b01;
    localparam logic [1:0]  PC_BRANCH        = 2'b10;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with flush, stall and bubble load.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    // A bubble clears instruction and valid but leaves PC+4 untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            if (i_load) begin
                r_instr <= i_instr;
                r_pc4   <= i_pc4;
                r_valid <= 1'b1;
            end else begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Instruction fetch with redirect, skid buffer and IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] BranchTarget,
    input  logic        IF_ID_Stall,
    input  logic        IF_ID_Flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr_IF_ID,
    output logic [31:0] PC4_IF_ID,
    output logic        Valid_IF_ID,
    output logic        fetch_busy
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_target;
    logic         r_skid_valid;
    logic [31:0]  r_skid_instr;
    logic [31:0]  r_skid_pc4;

    logic         w_redirect;
    logic [31:0]  w_target;
    logic [31:0]  w_pc_plus4;
    logic         w_ifid_load;
    logic [31:0]  w_ifid_instr;
    logic [31:0]  w_ifid_pc4;

    always_comb begin
        w_redirect = 1'b0;
        w_target   = 32'h0000_0000;
        case (PCSrc)
            PC_JUMP: begin
                w_redirect = 1'b1;
                w_target   = word_align(JumpTarget);
            end
            PC_BRANCH: begin
                w_redirect = 1'b1;
                w_target   = word_align(BranchTarget);
            end
            default: begin
                w_redirect = 1'b0;
            end
        endcase
    end

    assign w_pc_plus4 = r_pc + 32'd4;

    // In DISCARD r_pc still names the outstanding request; the redirect
    // target waits in r_target until that request is acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_target     <= 32'h0000_0000;
            r_skid_valid <= 1'b0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc4   <= 32'h0000_0000;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_redirect) begin
                        if (imem_ack) begin
                            r_pc <= w_target;
                        end else begin
                            r_target <= w_target;
                            r_state  <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        r_pc <= w_pc_plus4;
                        if (IF_ID_Stall && !IF_ID_Flush) begin
                            r_skid_valid <= 1'b1;
                            r_skid_instr <= imem_rdata;
                            r_skid_pc4   <= w_pc_plus4;
                            r_state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                    if (w_redirect || IF_ID_Flush || !IF_ID_Stall) begin
                        r_skid_valid <= 1'b0;
                        r_state      <= FETCH;
                    end
                end
                DISCARD: begin
                    if (w_redirect) begin
                        r_target <= w_target;
                    end
                    if (imem_ack) begin
                        r_pc    <= w_redirect ? w_target : r_target;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign w_ifid_load  = ((r_state == FETCH) && imem_ack) ||
                          ((r_state == HOLD) && r_skid_valid);
    assign w_ifid_instr = (r_state == HOLD) ? r_skid_instr : imem_rdata;
    assign w_ifid_pc4   = (r_state == HOLD) ? r_skid_pc4   : w_pc_plus4;

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (IF_ID_Flush | w_redirect),
        .i_stall (IF_ID_Stall),
        .i_load  (w_ifid_load),
        .i_instr (w_ifid_instr),
        .i_pc4   (w_ifid_pc4),
        .o_instr (Instr_IF_ID),
        .o_pc4   (PC4_IF_ID),
        .o_valid (Valid_IF_ID)
    );

    assign imem_req   = (r_state != HOLD);
    assign imem_addr  = r_pc;
    assign fetch_busy = imem_req && !imem_ack;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Self-checking bench for if_fetch_unit against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] JumpTarget = 32'h0;
    logic [31:0] BranchTarget = 32'h0;
    logic        IF_ID_Stall = 1'b0;
    logic        IF_ID_Flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] Instr_IF_ID;
    logic [31:0] PC4_IF_ID;
    logic        Valid_IF_ID;
    logic        fetch_busy;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    // Reference model: next fetch address, pending redirect, parked entries.
    logic [31:0] m_pc;
    bit          m_disc;
    logic [31:0] m_dtgt;
    ent_t        m_skid[$];
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;
    logic [31:0] rd_xor = 32'h0;

    if_fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCSrc        (PCSrc),
        .JumpTarget   (JumpTarget),
        .BranchTarget (BranchTarget),
        .IF_ID_Stall  (IF_ID_Stall),
        .IF_ID_Flush  (IF_ID_Flush),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .Instr_IF_ID  (Instr_IF_ID),
        .PC4_IF_ID    (PC4_IF_ID),
        .Valid_IF_ID  (Valid_IF_ID),
        .fetch_busy   (fetch_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = C_RESET_PC;
        m_disc  = 1'b0;
        m_dtgt  = 32'h0;
        m_skid.delete();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_update(input logic [1:0] src, input logic [31:0] jt, input logic [31:0] bt,
                                input bit st, input bit fl, input bit ak, input logic [31:0] rd);
        bit          redir;
        logic [31:0] tgt;
        ent_t        e;
        redir = (src == 2'b01) || (src == 2'b10);
        tgt   = ((src == 2'b01) ? jt : bt) & 32'hFFFF_FFFC;
        if (m_skid.size() != 0) begin
            if (redir || fl) begin
                m_skid.delete();
                if (redir) m_pc = tgt;
                model_bubble();
            end else if (!st) begin
                m_instr = m_skid[0].instr;
                m_pc4   = m_skid[0].pc4;
                m_valid = 1'b1;
                m_skid.delete();
            end
        end else if (m_disc) begin
            if (redir) m_dtgt = tgt;
            if (ak) begin
                m_pc   = m_dtgt;
                m_disc = 1'b0;
            end
            if (redir || fl || !st) model_bubble();
        end else if (redir) begin
            model_bubble();
            if (ak) m_pc = tgt;
            else begin
                m_disc = 1'b1;
                m_dtgt = tgt;
            end
        end else if (ak) begin
            if (fl) model_bubble();
            else if (st) begin
                e.instr = rd;
                e.pc4   = m_pc + 32'd4;
                m_skid.push_back(e);
            end else begin
                m_instr = rd;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (fl || !st) begin
            model_bubble();
        end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input logic [1:0] src, input logic [31:0] jt, input logic [31:0] bt,
                        input bit st, input bit fl, input bit ak);
        bit exp_req;
        PCSrc        = src;
        JumpTarget   = jt;
        BranchTarget = bt;
        IF_ID_Stall  = st;
        IF_ID_Flush  = fl;
        imem_ack     = ak;
        imem_rdata   = m_pc ^ rd_xor;
        exp_req      = (m_skid.size() == 0);
        #1;
        check_eq("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
        check_eq("fetch_busy", 32'(fetch_busy), 32'(exp_req && !ak));
        @(posedge clk);
        model_update(src, jt, bt, st, fl, ak, imem_rdata);
        #1;
        check_eq("instr", Instr_IF_ID, m_instr);
        check_eq("pc4", PC4_IF_ID, m_pc4);
        check_eq("valid", 32'(Valid_IF_ID), 32'(m_valid));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_instr", Instr_IF_ID, 32'h0);
        check_eq("rst_pc4", PC4_IF_ID, 32'h0);
        check_eq("rst_valid", 32'(Valid_IF_ID), 32'h0);
        check_eq("rst_req", 32'(imem_req), 32'h1);
        check_eq("rst_addr", imem_addr, C_RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic seq_acks(input int n);
        for (int k = 0; k < n; k++) step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] s;
        int         r;
        @(negedge clk);
        do_reset();

        // Back-to-back zero-wait fetches from reset
        for (int k = 0; k < 3; k++) begin
            step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
            check_eq("seq_instr", Instr_IF_ID, 32'(4 * k));
            check_eq("seq_valid", 32'(Valid_IF_ID), 32'h1);
        end
        seq_acks(1);

        // Delayed ack at 0x10
        for (int k = 0; k < 3; k++) begin
            step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            check_eq("wait_valid", 32'(Valid_IF_ID), 32'h0);
        end
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("wait_instr", Instr_IF_ID, 32'h10);
        seq_acks(3);

        // Stall while ack arrives at 0x20
        step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        check_eq("stall_hold", Instr_IF_ID, 32'h1C);
        check_eq("stall_req", 32'(imem_req), 32'h0);
        step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("skid_instr", Instr_IF_ID, 32'h20);
        check_eq("skid_pc4", PC4_IF_ID, 32'h24);
        seq_acks(7);

        // Jump while request at 0x40 is pending
        step(2'b01, 32'h103, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("disc_addr", imem_addr, 32'h40);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("disc_drop", 32'(Valid_IF_ID), 32'h0);
        check_eq("jump_addr", imem_addr, 32'h100);

        // Latest redirect wins while discarding
        step(2'b01, 32'h180, 32'h0, 1'b0, 1'b0, 1'b0);
        step(2'b10, 32'h0, 32'h200, 1'b0, 1'b0, 1'b0);
        step(2'b01, 32'h300, 32'h0, 1'b0, 1'b0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("latest_addr", imem_addr, 32'h300);

        // Flush beats stall, then reset mid-DISCARD
        seq_acks(1);
        step(2'b01, 32'h400, 32'h0, 1'b0, 1'b0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        check_eq("flush_valid", 32'(Valid_IF_ID), 32'h0);
        do_reset();
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rd_xor = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 9);
                s = (r < 7) ? 2'b00 : (r == 7) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
                step(s, $urandom, $urandom, ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
